mem_port_arbiter: RTL

- Shares one single-port 16-bit synchronous RAM between instruction fetch (read-only) and data memory (read/write).
- Grants one requester per cycle and tracks the in-flight read so its data returns to the correct side one cycle later.
- Produces the fetch stall.
- Sits between the fetch stage, the memory stage and the shared RAM instance.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction fetch port (read-only) and the data memory port (read/write).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_req, if_addr       fetch read request and PC
//   if_gnt                fetch read issued to the RAM this cycle
//   if_rvalid, if_rdata   instruction return, one cycle after if_gnt
//   stall_if              fetch must hold its PC (if_req & ~if_gnt)
//   flush                 redirect: kills this cycle's fetch grant and return
//   dm_req, dm_wr         data request, 1 = write / 0 = read
//   dm_addr, dm_wdata     data address and store data
//   dm_gnt                data access issued to the RAM this cycle
//   dm_rvalid, dm_rdata   load return, one cycle after a read dm_gnt
//   mem_addr, mem_data,
//   mem_wren, mem_q       shared RAM interface (mem_q = data for the address
//                         sampled on the previous rising edge)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              flush,
  // data side
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // shared RAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_DM_RD = 2'd2
  } owner_t;

  owner_t           owner_q;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  logic if_ok;
  logic fetch_turn;
  logic if_gnt_w;
  logic dm_gnt_w;

  // Grant decision: data wins contention until fetch has waited STARVE_MAX
  // grants in a row; nothing is granted while reset is held.
  always_comb begin
    if_ok      = if_req & ~flush;
    fetch_turn = (starve_q == CNT_W'(STARVE_MAX));
    if_gnt_w   = 1'b0;
    dm_gnt_w   = 1'b0;
    if (!rst) begin
      if (if_ok && dm_req) begin
        if (fetch_turn) if_gnt_w = 1'b1;
        else            dm_gnt_w = 1'b1;
      end else if (if_ok) begin
        if_gnt_w = 1'b1;
      end else if (dm_req) begin
        dm_gnt_w = 1'b1;
      end
    end
  end

  // Starvation count: saturating count of data grants taken while fetch waits.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt_w || !if_ok) begin
      starve_d = '0;
    end else if (dm_gnt_w && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Read owner tracker: remembers which side the RAM output belongs to next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (if_gnt_w) begin
        owner_q <= OWN_IF_RD;
      end else if (dm_gnt_w && !dm_wr) begin
        owner_q <= OWN_DM_RD;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // RAM drive: the fetch address parks on the bus whenever data is not granted.
  always_comb begin
    mem_addr = dm_gnt_w ? dm_addr : if_addr;
    mem_data = dm_wdata;
    mem_wren = dm_gnt_w & dm_wr;
  end

  // Read return; a flush also kills the fetch issued in the previous cycle.
  always_comb begin
    if_gnt    = if_gnt_w;
    dm_gnt    = dm_gnt_w;
    stall_if  = if_req & ~if_gnt_w;
    if_rvalid = (owner_q == OWN_IF_RD) & ~flush;
    dm_rvalid = (owner_q == OWN_DM_RD);
    if_rdata  = mem_q;
    dm_rdata  = mem_q;
  end

endmodule
